// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART TX packet path.
// Holds the FSM encoding, byte/word widths and the byte-count encoding.
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 2;

  // req_len carries byte count minus one
  localparam logic [LEN_W-1:0] LEN_1 = 2'd0;
  localparam logic [LEN_W-1:0] LEN_2 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_3 = 2'd2;
  localparam logic [LEN_W-1:0] LEN_4 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  // Little-endian byte pick: idx 0 is bits [7:0]
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic [LEN_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < (WORD_W / BYTE_W); i++) begin
      if (idx == LEN_W'(i)) b = word[i*BYTE_W +: BYTE_W];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side packet bus plus byte-level UART TX handshake.
// master: requesters and UART TX; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  import uart_ctrl_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [WORD_W*N_REQ-1:0] req_data;
  logic [LEN_W*N_REQ-1:0]  req_len;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    busy;

  modport master (
    output req, req_data, req_len, tx_busy,
    input  grant, done, tx_data, tx_start, busy
  );

  modport slave (
    input  req, req_data, req_len, tx_busy,
    output grant, done, tx_data, tx_start, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping to 0. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid_c,
  output logic [IDX_W-1:0] winner_c
);

  int unsigned pos;

  always_comb begin
    valid_c  = 1'b0;
    winner_c = '0;
    pos      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!valid_c && req[IDX_W'(pos)]) begin
        valid_c  = 1'b1;
        winner_c = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ word requesters: round-robin grant,
// latch the winner's word, then send 1-4 bytes LSB-first over start/busy.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;

  logic               win_valid_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic [WORD_W-1:0]  win_word_c;
  logic [LEN_W-1:0]   win_len_c;
  logic [LEN_W-1:0]   idx_next_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req      (bus.req),
    .ptr      (ptr_q),
    .valid_c  (win_valid_c),
    .winner_c (win_idx_c)
  );

  // Select the winner's word and length out of the flattened buses
  always_comb begin
    win_word_c = '0;
    win_len_c  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx_c == IDX_W'(k)) begin
        win_word_c = bus.req_data[k*WORD_W +: WORD_W];
        win_len_c  = bus.req_len[k*LEN_W +: LEN_W];
      end
    end
  end

  assign idx_next_c = LEN_W'(idx_q + 1'b1);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cur_q      <= '0;
      word_q     <= '0;
      len_q      <= LEN_1;
      idx_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      word_q     <= word_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; pulse outputs are computed one cycle ahead of their state.
  // Follow-on bytes go straight from WAIT_DONE to WAIT_ACK so tx_start lands
  // the cycle after tx_busy falls.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    word_d     = word_q;
    len_d      = len_q;
    idx_d      = idx_q;
    grant_d    = '0;
    done_d     = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_valid_c && !bus.tx_busy) begin
          cur_d   = win_idx_c;
          word_d  = win_word_c;
          len_d   = win_len_c;
          idx_d   = '0;
          grant_d = N_REQ'(1) << win_idx_c;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        tx_data_d  = byte_sel(word_q, idx_q);
        tx_start_d = 1'b1;
        state_d    = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == len_q) begin
            done_d  = N_REQ'(1) << cur_q;
            state_d = S_FINISH;
          end else begin
            idx_d      = idx_next_c;
            tx_data_d  = byte_sel(word_q, idx_next_c);
            tx_start_d = 1'b1;
            state_d    = S_WAIT_ACK;
          end
        end
      end

      S_FINISH: begin
        ptr_d   = (cur_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(cur_q + 1'b1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART TX model that holds
// tx_busy for a fixed number of cycles per byte.
module tb_uart_tx_arbiter;

  localparam int unsigned N        = 2;
  localparam int unsigned BUSY_CYC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.N_REQ(N)) bus();

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc        = 0;
  int   checks     = 0;
  int   failures   = 0;
  logic bfm_busy   = 1'b0;
  int   bfm_cnt    = 0;
  logic force_busy = 1'b0;

  assign bus.tx_busy = bfm_busy | force_busy;

  // UART TX model: busy from the cycle after tx_start for BUSY_CYC cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_start) begin
      bfm_busy <= 1'b1;
      bfm_cnt  <= BUSY_CYC - 1;
    end else if (bfm_busy) begin
      if (bfm_cnt == 0) bfm_busy <= 1'b0;
      else              bfm_cnt  <= bfm_cnt - 1;
    end
  end

  logic [7:0]   tx_log[$];
  int           start_cyc[$];
  int           fall_cyc[$];
  logic [N-1:0] grant_log[$];
  logic [N-1:0] done_log[$];
  int           done_cyc[$];
  logic         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      tx_log.push_back(bus.tx_data);
      start_cyc.push_back(cyc);
    end
    if (bus.grant != '0) grant_log.push_back(bus.grant);
    if (bus.done != '0) begin
      done_log.push_back(bus.done);
      done_cyc.push_back(cyc);
    end
    if (prev_busy && !bus.tx_busy) fall_cyc.push_back(cyc);
    prev_busy = bus.tx_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $display("FAIL timeout_%s observed=no_event expected=event", tag);
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic logic [31:0] qb(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hDEAD_0000;
  endfunction

  task automatic clear_logs();
    tx_log.delete(); start_cyc.delete(); fall_cyc.delete();
    grant_log.delete(); done_log.delete(); done_cyc.delete();
  endtask

  task automatic set_req(input int k, input logic [31:0] d, input logic [1:0] l);
    bus.req_data[32*k +: 32] = d;
    bus.req_len[2*k +: 2]    = l;
    bus.req[k]               = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        g = bus.grant;
        return;
      end
    end
    timeout("grant");
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.done != '0) seen++;
      if (seen == n) return;
    end
    timeout("done");
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp [4];
    exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
    check({tag, "_nbytes"}, 32'(tx_log.size()), 32'(n));
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), qb(tx_log, i), 32'(exp[i]));
  endtask

  initial begin
    logic [N-1:0] g;
    int t0;
    int rel;
    int n;

    bus.req = '0;
    bus.req_data = '0;
    bus.req_len = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_tx_start", 32'(bus.tx_start), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();

    // 4-byte word from requester 0
    set_req(0, 32'hA1B2C3D4, 2'd3);
    t0 = cyc;
    wait_grant(g);
    bus.req[0] = 1'b0;
    check("t1_grant", 32'(g), 32'h1);
    check("t1_grant_lat", 32'(cyc - t0), 32'd1);
    check("t1_busy_on", 32'(bus.busy), 32'h1);
    wait_done(1);
    repeat (3) @(negedge clk);
    check("t1_busy_off", 32'(bus.busy), 32'h0);
    check_bytes("t1", 4, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
    check("t1_start_lat", 32'(qi(start_cyc, 0) - t0), 32'd2);
    check("t1_gap1", 32'(qi(start_cyc, 1) - qi(fall_cyc, 0)), 32'd1);
    check("t1_gap3", 32'(qi(start_cyc, 3) - qi(fall_cyc, 2)), 32'd1);
    check("t1_ngrant", 32'(grant_log.size()), 32'd1);
    check("t1_ndone", 32'(done_log.size()), 32'd1);
    check("t1_done_vec", (done_log.size() > 0) ? 32'(done_log[0]) : 32'hDEAD, 32'h1);
    check("t1_done_lat", 32'(qi(done_cyc, 0) - qi(fall_cyc, 3)), 32'd1);
    clear_logs();

    // Single byte from requester 1
    set_req(1, 32'h0000005A, 2'd0);
    wait_grant(g);
    bus.req[1] = 1'b0;
    check("t2_grant", 32'(g), 32'h2);
    wait_done(1);
    repeat (3) @(negedge clk);
    check_bytes("t2", 1, 8'h5A, 8'h00, 8'h00, 8'h00);
    check("t2_done_vec", (done_log.size() > 0) ? 32'(done_log[0]) : 32'hDEAD, 32'h2);
    check("t2_done_lat", 32'(qi(done_cyc, 0) - qi(fall_cyc, 0)), 32'd1);
    clear_logs();

    // Both held from reset: grants alternate
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'h000000C0, 2'd0);
    set_req(1, 32'h000000C1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      check($sformatf("t3_grant%0d", i), 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    bus.req = '0;
    wait_done(1);
    repeat (3) @(negedge clk);
    check_bytes("t3", 4, 8'hC0, 8'hC1, 8'hC0, 8'hC1);
    clear_logs();

    // tx_busy held high in IDLE blocks the grant
    force_busy = 1'b1;
    set_req(0, 32'h00000077, 2'd0);
    repeat (6) @(negedge clk);
    check("t4_no_grant", 32'(grant_log.size()), 32'd0);
    force_busy = 1'b0;
    rel = cyc;
    wait_grant(g);
    bus.req[0] = 1'b0;
    check("t4_grant", 32'(g), 32'h1);
    check("t4_grant_lat", 32'(cyc - rel), 32'd1);
    wait_done(1);
    repeat (3) @(negedge clk);
    clear_logs();

    // Reset after the second byte of a 4-byte word
    set_req(0, 32'hDEADBEEF, 2'd3);
    wait_grant(g);
    bus.req[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (bus.tx_start) n++;
    end
    if (n < 2) timeout("t5_second_byte");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("t5_rst_busy", 32'(bus.busy), 32'h0);
    check("t5_rst_tx_start", 32'(bus.tx_start), 32'h0);
    check("t5_rst_done", 32'(bus.done), 32'h0);
    clear_logs();
    set_req(0, 32'h000000E0, 2'd0);
    set_req(1, 32'h11223344, 2'd3);
    wait_grant(g);
    bus.req[0] = 1'b0;
    check("t5_ptr_reset_winner", 32'(g), 32'h1);
    check("t5_wait_inflight", 32'(cyc - qi(fall_cyc, 0)), 32'd1);
    check("t5_no_done", 32'(done_log.size()), 32'd0);
    wait_grant(g);
    bus.req[1] = 1'b0;
    check("t5_second_winner", 32'(g), 32'h2);
    wait_done(1);
    repeat (3) @(negedge clk);
    check("t5_nbytes", 32'(tx_log.size()), 32'd5);
    check("t5_first_byte_r1", qb(tx_log, 1), 32'h44);
    check("t5_last_byte_r1", qb(tx_log, 4), 32'h11);
    clear_logs();

    // Word latched at grant; later req_data changes ignored
    set_req(0, 32'hCAFEF00D, 2'd3);
    wait_grant(g);
    bus.req_data[31:0] = 32'hFFFFFFFF;
    bus.req[0] = 1'b0;
    check("t6_grant", 32'(g), 32'h1);
    wait_done(1);
    repeat (3) @(negedge clk);
    check_bytes("t6", 4, 8'h0D, 8'hF0, 8'hFE, 8'hCA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
